// File: rtl/csr_pkg.sv
// CSR addresses, mstatus bit positions and cause codes shared by the
// trap sequencer and its neighbours.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [1:0] PRIV_M = 2'b11;
  localparam logic [1:0] PRIV_U = 2'b00;

  localparam int CAUSE_ECALL_M = 11;

endpackage

// File: rtl/trap_seq_if.sv
// Trap request, execute-stage CSR access, CSR file port and fetch redirect
// bundle around the trap sequencer.
interface trap_seq_if #(
   parameter int XLEN = 64
) ();

   logic            trap_valid;
   logic            trap_is_mret;
   logic [XLEN-1:0] trap_pc;
   logic            trap_ready;

   logic [11:0]     ex_csr_addr;
   logic [XLEN-1:0] ex_csr_wdata;
   logic            ex_csr_wen;
   logic            ex_csr_sen;

   logic [11:0]     csr_addr;
   logic [XLEN-1:0] csr_wdata;
   logic            csr_wen;
   logic            csr_sen;
   logic [XLEN-1:0] csr_rdata;

   logic            stall;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;

   modport slave (
      input  trap_valid, trap_is_mret, trap_pc,
      input  ex_csr_addr, ex_csr_wdata, ex_csr_wen, ex_csr_sen,
      input  csr_rdata,
      output trap_ready, csr_addr, csr_wdata, csr_wen, csr_sen,
      output stall, redirect_valid, redirect_pc
   );

   modport master (
      output trap_valid, trap_is_mret, trap_pc,
      output ex_csr_addr, ex_csr_wdata, ex_csr_wen, ex_csr_sen,
      output csr_rdata,
      input  trap_ready, csr_addr, csr_wdata, csr_wen, csr_sen,
      input  stall, redirect_valid, redirect_pc
   );

endinterface

// File: rtl/trap_seq.sv
// Trap sequencer: owns the CSR file port during ecall/mret, serialising the
// CSR updates and issuing the fetch redirect; passes execute CSR traffic when idle.
module trap_seq
   import csr_pkg::*;
#(
   parameter int              XLEN        = 64,
   parameter logic [XLEN-1:0] ECALL_CAUSE = XLEN'(CAUSE_ECALL_M)
) (
   input logic       clock,
   input logic       reset,
   trap_seq_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      E_EPC   = 3'd1,
      E_CAUSE = 3'd2,
      E_STAT  = 3'd3,
      E_VEC   = 3'd4,
      R_STAT  = 3'd5,
      R_EPC   = 3'd6
   } state_t;

   state_t          state, state_next;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] status_entry;
   logic [XLEN-1:0] status_exit;

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= IDLE;
         pc_q  <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE && bus.trap_valid) pc_q <= bus.trap_pc;
      end
   end

   // mstatus images written on trap entry and trap return.
   always_comb begin
      status_entry                               = bus.csr_rdata;
      status_entry[MSTATUS_MPIE]                 = bus.csr_rdata[MSTATUS_MIE];
      status_entry[MSTATUS_MIE]                  = 1'b0;
      status_entry[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_M;

      status_exit                                = bus.csr_rdata;
      status_exit[MSTATUS_MIE]                   = bus.csr_rdata[MSTATUS_MPIE];
      status_exit[MSTATUS_MPIE]                  = 1'b1;
      status_exit[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_U;
   end

   // NOTE: every output gets a default first so no path infers a latch.
   always_comb begin
      state_next         = state;
      bus.trap_ready     = 1'b0;
      bus.stall          = 1'b1;
      bus.csr_addr       = '0;
      bus.csr_wdata      = '0;
      bus.csr_wen        = 1'b0;
      bus.csr_sen        = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;

      case (state)
         IDLE: begin
            bus.trap_ready = 1'b1;
            bus.stall      = bus.trap_valid;
            bus.csr_addr   = bus.ex_csr_addr;
            bus.csr_wdata  = bus.ex_csr_wdata;
            bus.csr_wen    = bus.ex_csr_wen;
            bus.csr_sen    = bus.ex_csr_sen;
            if (bus.trap_valid) state_next = bus.trap_is_mret ? R_STAT : E_EPC;
         end
         E_EPC: begin
            bus.csr_addr  = CSR_MEPC;
            bus.csr_wdata = pc_q;
            bus.csr_wen   = 1'b1;
            state_next    = E_CAUSE;
         end
         E_CAUSE: begin
            bus.csr_addr  = CSR_MCAUSE;
            bus.csr_wdata = ECALL_CAUSE;
            bus.csr_wen   = 1'b1;
            state_next    = E_STAT;
         end
         E_STAT: begin
            bus.csr_addr  = CSR_MSTATUS;
            bus.csr_wdata = status_entry;
            bus.csr_wen   = 1'b1;
            state_next    = E_VEC;
         end
         E_VEC: begin
            // Direct mode only: the mode bits are dropped, never vectored.
            bus.csr_addr       = CSR_MTVEC;
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = {bus.csr_rdata[XLEN-1:2], 2'b00};
            state_next         = IDLE;
         end
         R_STAT: begin
            bus.csr_addr  = CSR_MSTATUS;
            bus.csr_wdata = status_exit;
            bus.csr_wen   = 1'b1;
            state_next    = R_EPC;
         end
         R_EPC: begin
            bus.csr_addr       = CSR_MEPC;
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = bus.csr_rdata;
            state_next         = IDLE;
         end
         default: state_next = IDLE;
      endcase

      // A reset cycle must not commit the in-flight CSR write or redirect.
      if (!reset) begin
         bus.csr_wen        = 1'b0;
         bus.csr_sen        = 1'b0;
         bus.redirect_valid = 1'b0;
         bus.redirect_pc    = '0;
      end
   end

endmodule

// File: tb/tb_trap_seq.sv
// Bench for trap_seq: a behavioural CSR file on the port, randomised traps and
// execute-stage noise, checked against an architectural model of the CSRs.
module tb_trap_seq;
   import csr_pkg::*;

   localparam int XLEN = 64;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   trap_seq_if #(.XLEN(XLEN)) bus ();

   trap_seq #(.XLEN(XLEN), .ECALL_CAUSE(64'd11)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   int errors = 0;
   int checks = 0;

   // CSR file seen by the DUT (combinational read, write/set on posedge).
   logic [63:0] f_mepc = '0, f_mcause = '0, f_mstatus = '0, f_mtvec = '0;
   // Architectural model of what those CSRs should hold.
   logic [63:0] m_mepc = '0, m_mcause = '0, m_mstatus = '0, m_mtvec = '0;

   always_comb begin
      case (bus.csr_addr)
         CSR_MEPC:    bus.csr_rdata = f_mepc;
         CSR_MCAUSE:  bus.csr_rdata = f_mcause;
         CSR_MSTATUS: bus.csr_rdata = f_mstatus;
         CSR_MTVEC:   bus.csr_rdata = f_mtvec;
         default:     bus.csr_rdata = '0;
      endcase
   end

   function automatic logic [63:0] upd(input logic [63:0] old, input logic wen,
                                       input logic [63:0] d);
      return wen ? d : (old | d);
   endfunction

   always @(posedge clock) begin
      if (bus.csr_wen || bus.csr_sen) begin
         case (bus.csr_addr)
            CSR_MEPC:    f_mepc    <= upd(f_mepc, bus.csr_wen, bus.csr_wdata);
            CSR_MCAUSE:  f_mcause  <= upd(f_mcause, bus.csr_wen, bus.csr_wdata);
            CSR_MSTATUS: f_mstatus <= upd(f_mstatus, bus.csr_wen, bus.csr_wdata);
            CSR_MTVEC:   f_mtvec   <= upd(f_mtvec, bus.csr_wen, bus.csr_wdata);
            default: ;
         endcase
      end
   end

   // Trap entry: MPIE takes MIE, MIE clears, MPP becomes M. Return: MIE takes MPIE, MPIE sets, MPP becomes U.
   function automatic logic [63:0] model_entry(input logic [63:0] s);
      return (s & ~64'h1888) | (s[3] ? 64'h80 : 64'h0) | 64'h1800;
   endfunction

   function automatic logic [63:0] model_exit(input logic [63:0] s);
      return (s & ~64'h1888) | (s[7] ? 64'h8 : 64'h0) | 64'h80;
   endfunction

   task automatic compare_csrs(input string tag);
      checks++;
      if (f_mepc !== m_mepc || f_mcause !== m_mcause || f_mstatus !== m_mstatus || f_mtvec !== m_mtvec) begin
         errors++;
         $display("FAIL %s csr_state: got mepc=%h mcause=%h mstatus=%h mtvec=%h expected mepc=%h mcause=%h mstatus=%h mtvec=%h",
                  tag, f_mepc, f_mcause, f_mstatus, f_mtvec, m_mepc, m_mcause, m_mstatus, m_mtvec);
      end
   endtask

   // Write a CSR through the idle pass-through path and track it in the model.
   task automatic csr_write(input logic [11:0] a, input logic [63:0] d);
      @(negedge clock);
      bus.ex_csr_addr  = a;
      bus.ex_csr_wdata = d;
      bus.ex_csr_wen   = 1'b1;
      bus.ex_csr_sen   = 1'b0;
      #1;
      checks++;
      if (bus.csr_wen !== 1'b1 || bus.csr_addr !== a || bus.csr_wdata !== d || bus.stall !== 1'b0) begin
         errors++;
         $display("FAIL passthru_write: got addr=%h wdata=%h wen=%b stall=%b expected addr=%h wdata=%h wen=1 stall=0",
                  bus.csr_addr, bus.csr_wdata, bus.csr_wen, bus.stall, a, d);
      end
      @(negedge clock);
      bus.ex_csr_wen = 1'b0;
      case (a)
         CSR_MEPC:    m_mepc    = d;
         CSR_MCAUSE:  m_mcause  = d;
         CSR_MSTATUS: m_mstatus = d;
         CSR_MTVEC:   m_mtvec   = d;
         default: ;
      endcase
   endtask

   // Present one trap request in the current cycle (caller is between negedge and posedge),
   // then follow it to the idle cycle after the redirect, jamming the execute inputs meanwhile.
   task automatic do_trap(input bit is_mret, input logic [63:0] pc, input string tag);
      int          busy, pulses, pulse_at;
      logic [63:0] pulse_pc, exp_pc;
      bit          back_idle;
      busy      = is_mret ? 2 : 4;
      exp_pc    = is_mret ? m_mepc : (m_mtvec & ~64'h3);
      pulses    = 0;
      pulse_at  = 0;
      pulse_pc  = '0;
      back_idle = 1'b0;

      bus.trap_valid   = 1'b1;
      bus.trap_is_mret = is_mret;
      bus.trap_pc      = pc;
      bus.ex_csr_wen   = 1'b0;
      bus.ex_csr_sen   = 1'b0;
      #1;
      checks++;
      if (bus.stall !== 1'b1 || bus.trap_ready !== 1'b1 || bus.redirect_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s accept: got stall=%b ready=%b redirect=%b expected 1 1 0",
                  tag, bus.stall, bus.trap_ready, bus.redirect_valid);
      end

      for (int k = 1; k <= busy + 4 && !back_idle; k++) begin
         @(negedge clock);
         bus.trap_valid   = 1'b0;
         bus.trap_is_mret = 1'($urandom);
         bus.trap_pc      = {$urandom, $urandom};
         if (k <= busy) begin
            case ($urandom_range(0, 3))
               0:       bus.ex_csr_addr = CSR_MEPC;
               1:       bus.ex_csr_addr = CSR_MCAUSE;
               2:       bus.ex_csr_addr = CSR_MSTATUS;
               default: bus.ex_csr_addr = CSR_MTVEC;
            endcase
            bus.ex_csr_wdata = {$urandom, $urandom};
            bus.ex_csr_wen   = 1'($urandom);
            bus.ex_csr_sen   = 1'($urandom);
         end else begin
            bus.ex_csr_wen = 1'b0;
            bus.ex_csr_sen = 1'b0;
         end
         #1;
         if (bus.redirect_valid === 1'b1) begin
            pulses++;
            pulse_at = k;
            pulse_pc = bus.redirect_pc;
         end
         if (k <= busy) begin
            checks++;
            if (bus.stall !== 1'b1 || bus.trap_ready !== 1'b0 || bus.csr_sen !== 1'b0) begin
               errors++;
               $display("FAIL %s busy_cycle%0d: got stall=%b ready=%b sen=%b expected 1 0 0",
                        tag, k, bus.stall, bus.trap_ready, bus.csr_sen);
            end
         end else if (bus.stall === 1'b0) begin
            back_idle = 1'b1;
         end
      end

      checks++;
      if (!back_idle) begin
         errors++;
         $display("FAIL %s stall_release: got stall held past cycle %0d expected release at cycle %0d",
                  tag, busy + 4, busy + 1);
      end
      checks++;
      if (pulses != 1 || pulse_at != busy) begin
         errors++;
         $display("FAIL %s redirect_timing: got %0d pulses last at cycle %0d expected 1 pulse at cycle %0d",
                  tag, pulses, pulse_at, busy);
      end
      checks++;
      if (pulse_pc !== exp_pc) begin
         errors++;
         $display("FAIL %s redirect_pc: got %h expected %h", tag, pulse_pc, exp_pc);
      end

      if (is_mret) begin
         m_mstatus = model_exit(m_mstatus);
      end else begin
         m_mepc    = pc;
         m_mcause  = 64'd11;
         m_mstatus = model_entry(m_mstatus);
      end
      compare_csrs(tag);
   endtask

   task automatic test_reset();
      reset            = 1'b0;
      bus.trap_valid   = 1'b0;
      bus.trap_is_mret = 1'b0;
      bus.trap_pc      = '0;
      bus.ex_csr_addr  = '0;
      bus.ex_csr_wdata = '0;
      bus.ex_csr_wen   = 1'b0;
      bus.ex_csr_sen   = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      #1;
      checks++;
      if (bus.stall !== 1'b0 || bus.redirect_valid !== 1'b0 || bus.trap_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_state: got stall=%b redirect=%b ready=%b expected 0 0 1",
                  bus.stall, bus.redirect_valid, bus.trap_ready);
      end
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_passthrough();
      logic [11:0] a;
      logic [63:0] d;
      logic        s;
      csr_write(CSR_MTVEC, 64'h8000_0100);
      checks++;
      if (f_mtvec !== 64'h8000_0100) begin
         errors++;
         $display("FAIL passthru_mtvec: got %h expected 0000000080000100", f_mtvec);
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         a = 12'h7C0 + 12'($urandom_range(0, 15));
         d = {$urandom, $urandom};
         s = 1'($urandom);
         bus.ex_csr_addr  = a;
         bus.ex_csr_wdata = d;
         bus.ex_csr_wen   = 1'b0;
         bus.ex_csr_sen   = s;
         #1;
         checks++;
         if (bus.csr_addr !== a || bus.csr_wdata !== d || bus.csr_sen !== s || bus.csr_wen !== 1'b0
             || bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL passthru_mirror%0d: got addr=%h wdata=%h sen=%b wen=%b stall=%b expected %h %h %b 0 0",
                     i, bus.csr_addr, bus.csr_wdata, bus.csr_sen, bus.csr_wen, bus.stall, a, d, s);
         end
      end
      @(negedge clock);
      bus.ex_csr_sen = 1'b0;
   endtask

   task automatic test_ecall_basic();
      csr_write(CSR_MSTATUS, 64'h8);
      @(negedge clock);
      do_trap(1'b0, 64'h8000_0010, "ecall_basic");
      checks++;
      if (f_mepc !== 64'h8000_0010 || f_mcause !== 64'd11 || f_mstatus !== 64'h1880) begin
         errors++;
         $display("FAIL ecall_vector: got mepc=%h mcause=%h mstatus=%h expected 80000010 b 1880",
                  f_mepc, f_mcause, f_mstatus);
      end
   endtask

   task automatic test_mret();
      csr_write(CSR_MEPC, 64'h8000_0014);
      csr_write(CSR_MSTATUS, 64'h1880);
      @(negedge clock);
      do_trap(1'b1, 64'h8000_0044, "mret_basic");
      checks++;
      if (f_mstatus !== 64'h88) begin
         errors++;
         $display("FAIL mret_vector: got mstatus=%h expected 88", f_mstatus);
      end
   endtask

   task automatic test_mtvec_align();
      csr_write(CSR_MTVEC, 64'h8000_0103);
      @(negedge clock);
      do_trap(1'b0, 64'h8000_0200, "mtvec_align");
   endtask

   task automatic test_reset_mid();
      logic [63:0] pc;
      pc = 64'h8000_0020;
      csr_write(CSR_MCAUSE, 64'h5);
      @(negedge clock);
      bus.trap_valid   = 1'b1;
      bus.trap_is_mret = 1'b0;
      bus.trap_pc      = pc;
      @(negedge clock);
      bus.trap_valid = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      #1;
      checks++;
      if (bus.redirect_valid !== 1'b0) begin
         errors++;
         $display("FAIL abort_redirect: got %b expected 0", bus.redirect_valid);
      end
      @(negedge clock);
      reset = 1'b1;
      #1;
      checks++;
      if (bus.stall !== 1'b0 || bus.trap_ready !== 1'b1) begin
         errors++;
         $display("FAIL abort_idle: got stall=%b ready=%b expected 0 1", bus.stall, bus.trap_ready);
      end
      m_mepc = pc;
      compare_csrs("abort");
   endtask

   task automatic test_back_to_back();
      csr_write(CSR_MSTATUS, 64'h8);
      csr_write(CSR_MTVEC, 64'h8000_0100);
      @(negedge clock);
      do_trap(1'b0, 64'h8000_0300, "b2b_ecall");
      do_trap(1'b1, 64'h8000_0400, "b2b_mret");
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++) begin
         csr_write(CSR_MSTATUS, {$urandom, $urandom});
         csr_write(CSR_MTVEC, {$urandom, $urandom});
         if ($urandom_range(0, 1) == 1) csr_write(CSR_MEPC, {$urandom, $urandom});
         @(negedge clock);
         do_trap(1'($urandom), {$urandom, $urandom}, "random");
      end
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_ecall_basic();
      test_mret();
      test_mtvec_align();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
